// File: rtl/tmds_dec.sv
// TMDS receive decoder for one channel: symbol classification, data decode
// and word-alignment FSM that requests deserializer bit-slips until locked.
module tmds_dec #(
  parameter int CTRL_RUN   = 8,
  parameter int SEARCH_WIN = 4096,
  parameter int LOSS_WIN   = 4096,
  parameter int SLIP_WAIT  = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [9:0] tmds_data_i,
  input  logic       tmds_data_valid_i,
  output logic [7:0] px_data_o,
  output logic       px_data_valid_o,
  output logic       h_sync_o,
  output logic       v_sync_o,
  output logic       bitslip_o,
  output logic       locked_o
);

  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int SW = $clog2(SEARCH_WIN + 1);
  localparam int LW = $clog2(LOSS_WIN + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    SLIPW,
    LOCKED
  } state_e;

  state_e         state_q, state_d;
  logic [RW-1:0]  run_q, run_d;
  logic [SW-1:0]  sym_q, sym_d;
  logic [LW-1:0]  loss_q, loss_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           slip_q, slip_d;

  logic [9:0]     s1_q;
  logic           s1_vld_q;
  logic           s1_ctrl_q;
  logic [1:0]     s1_cb_q;

  logic           ctrl;
  logic [1:0]     cb;
  logic [7:0]     q;
  logic [7:0]     d;

  logic [7:0]     px_q;
  logic           pv_q;
  logic           hs_q;
  logic           vs_q;

  always_comb begin
    ctrl = 1'b1;
    cb   = 2'b00;
    unique case (tmds_data_i)
      TOK0:    cb = 2'b00;
      TOK1:    cb = 2'b01;
      TOK2:    cb = 2'b10;
      TOK3:    cb = 2'b11;
      default: ctrl = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q      <= '0;
      s1_vld_q  <= 1'b0;
      s1_ctrl_q <= 1'b0;
      s1_cb_q   <= '0;
    end else begin
      s1_vld_q <= tmds_data_valid_i;
      if (tmds_data_valid_i) begin
        s1_q      <= tmds_data_i;
        s1_ctrl_q <= ctrl;
        s1_cb_q   <= cb;
      end
    end
  end

  // Undo the optional inversion, then the XOR/XNOR chain.
  assign q = s1_q[9] ? ~s1_q[7:0] : s1_q[7:0];
  assign d = (q ^ {q[6:0], 1'b0}) ^ {{7{~s1_q[8]}}, 1'b0};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      px_q <= '0;
      pv_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else if (s1_vld_q) begin
      px_q <= '0;
      pv_q <= 1'b0;
      if (state_q == LOCKED) begin
        if (s1_ctrl_q) begin
          {vs_q, hs_q} <= s1_cb_q;
        end else begin
          px_q <= d;
          pv_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    sym_d   = sym_q;
    loss_d  = loss_q;
    wait_d  = wait_q;
    slip_d  = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (s1_vld_q) begin
          run_d = s1_ctrl_q ? run_q + RW'(1) : '0;
          sym_d = sym_q + SW'(1);
          if (run_d == RW'(CTRL_RUN)) begin
            state_d = LOCKED;
            run_d   = '0;
            sym_d   = '0;
            loss_d  = '0;
          end else if (sym_d == SW'(SEARCH_WIN)) begin
            state_d = SLIPW;
            slip_d  = 1'b1;
            wait_d  = '0;
          end
        end
      end
      SLIPW: begin
        wait_d = wait_q + WW'(1);
        if (wait_q == WW'(SLIP_WAIT - 1)) begin
          state_d = SEARCH;
          run_d   = '0;
          sym_d   = '0;
          wait_d  = '0;
        end
      end
      LOCKED: begin
        if (s1_vld_q) begin
          loss_d = s1_ctrl_q ? '0 : loss_q + LW'(1);
          if (loss_d == LW'(LOSS_WIN)) begin
            state_d = SEARCH;
            loss_d  = '0;
            run_d   = '0;
            sym_d   = '0;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= SEARCH;
      run_q   <= '0;
      sym_q   <= '0;
      loss_q  <= '0;
      wait_q  <= '0;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      sym_q   <= sym_d;
      loss_q  <= loss_d;
      wait_q  <= wait_d;
      slip_q  <= slip_d;
    end
  end

  assign px_data_o       = px_q;
  assign px_data_valid_o = pv_q;
  assign h_sync_o        = hs_q;
  assign v_sync_o        = vs_q;
  assign bitslip_o       = slip_q;
  assign locked_o        = (state_q == LOCKED);

endmodule
